// File: rtl/sram_arbiter_if.sv
// Bus bundle for sram_arbiter: fetch port, data port, SRAM side and status.
// The arbiter uses the slave modport; the requesters/SRAM side use master.
interface sram_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall;
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ack, d_rdata, d_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, stall, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall, busy
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between a fetch port and a data
// port. One transaction at a time: IDLE -> ACCESS (WAIT_CYCLES cycles) ->
// DONE (one-cycle ack) -> IDLE.
// Optional feature: define SRAM_ARB_ROUND_ROBIN_EN to alternate ties between
// the ports; without it the data port wins every tie.
module sram_arbiter #(
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    sram_arbiter_if.slave bus
);
    // A wait count of zero still needs one access cycle.
    localparam int WC    = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CNT_W = (WC > 1) ? $clog2(WC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              own_data_q, own_data_d;   // 1: data port owns the transaction
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              busy_q, busy_d;
    logic              grant_data_s;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic              last_data_q, last_data_d; // 1: last grant went to data

    // Tie goes to the port not granted last; a lone request always wins.
    always_comb begin
        if (bus.if_req && bus.d_req) begin
            grant_data_s = ~last_data_q;
        end else begin
            grant_data_s = bus.d_req;
        end
    end
`else
    // Data port wins every tie.
    always_comb begin
        grant_data_s = bus.d_req;
    end
`endif

    // Next-state and datapath logic for the three-state access FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        own_data_d = own_data_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        last_data_d = last_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    own_data_d = grant_data_s;
                    if (grant_data_s) begin
                        addr_d  = bus.d_addr;
                        wdata_d = bus.d_wdata;
                        we_d    = bus.d_we;
                    end else begin
                        addr_d  = bus.if_addr;
                        wdata_d = {DATA_W{1'b0}};
                        we_d    = 1'b0;
                    end
                    cnt_d   = CNT_LOAD;
                    state_d = ST_ACCESS;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    last_data_d = grant_data_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_ZERO) begin
                    // Last access cycle: read data is valid now; writes leave rdata alone.
                    if (!we_q && own_data_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end else if (!we_q) begin
                        if_rdata_d = bus.mem_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                    if_ack_d = ~own_data_q;
                    d_ack_d  = own_data_q;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = ST_ACCESS;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        mem_en_d = (state_d == ST_ACCESS);
        mem_we_d = (state_d == ST_ACCESS) && we_d;
        busy_d   = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_ZERO;
            own_data_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            wdata_q    <= {DATA_W{1'b0}};
            if_rdata_q <= {DATA_W{1'b0}};
            d_rdata_q  <= {DATA_W{1'b0}};
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_data_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            own_data_q <= own_data_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            busy_q     <= busy_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_data_q <= last_data_d;
`endif
        end
    end

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = busy_q;
    // Stall is combinational so it reflects a request in the very cycle it appears.
    assign bus.stall     = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed protocol cases followed by
// randomized traffic on both ports. Expected read data is pushed into
// per-port queues at issue time; a negedge monitor pops and compares on acks.
module tb_sram_arbiter;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int WC = 2;
    localparam int DEPTH = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] exp_if_q[$];
    logic [DW-1:0] exp_d_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] d_model;

    function automatic logic [DW-1:0] init_val(input int a);
        if (a == 5) return 32'hDEADBEEF;
        return 32'h5A5A0000 ^ (a * 32'h00010003);
    endfunction

    // SRAM model: combinational read, write on the clock edge.
    logic [DW-1:0] sram [DEPTH];
    logic sram_loaded = 1'b0;
    assign bus.mem_rdata = sram[bus.mem_addr];
    always @(posedge clk) begin
        if (!sram_loaded) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= init_val(i);
            sram_loaded <= 1'b1;
        end else if (bus.mem_en && bus.mem_we) begin
            sram[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_if(input int addr);
        exp_if_q.push_back(ref_mem[addr]);
    endtask

    task automatic push_d(input bit we, input int addr, input logic [DW-1:0] wdata);
        if (we) begin
            exp_d_q.push_back(d_model);
            ref_mem[addr] = wdata;
        end else begin
            d_model = ref_mem[addr];
            exp_d_q.push_back(d_model);
        end
    endtask

    // Monitor: stall rule, ack/mem_en exclusion, and scoreboard on every ack.
    always @(negedge clk) begin
        check("stall", {31'd0, bus.stall},
              {31'd0, (bus.if_req & ~bus.if_ack) | (bus.d_req & ~bus.d_ack)});
        if (bus.if_ack || bus.d_ack) check("ack_with_mem_en", {31'd0, bus.mem_en}, 32'd0);
        if (bus.if_ack) begin
            check("if_ack_expected", {31'd0, exp_if_q.size() > 0}, 32'd1);
            if (exp_if_q.size() > 0) check("if_rdata", bus.if_rdata, exp_if_q.pop_front());
        end
        if (bus.d_ack) begin
            check("d_ack_expected", {31'd0, exp_d_q.size() > 0}, 32'd1);
            if (exp_d_q.size() > 0) check("d_rdata", bus.d_rdata, exp_d_q.pop_front());
        end
    end

    // Uncontended transaction with cycle-exact latency checks.
    task automatic lat_txn(input bit is_d, input bit we, input int addr, input logic [DW-1:0] wdata);
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = AW'(addr); bus.d_wdata = wdata;
            push_d(we, addr, wdata);
        end else begin
            bus.if_req = 1'b1; bus.if_addr = AW'(addr);
            push_if(addr);
        end
        for (int k = 1; k <= WC; k++) begin
            tick();
            check("access_mem_en", {31'd0, bus.mem_en}, 32'd1);
            check("access_mem_addr", {21'd0, bus.mem_addr}, addr);
            check("access_mem_we", {31'd0, bus.mem_we}, {31'd0, is_d & we});
            check("access_no_ack", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
        end
        tick();
        check("ack_latency", {30'd0, bus.if_ack, bus.d_ack}, is_d ? 32'd1 : 32'd2);
        check("done_mem_en", {31'd0, bus.mem_en}, 32'd0);
        bus.if_req = 1'b0; bus.d_req = 1'b0; bus.d_we = 1'b0;
        tick();
        check("ack_one_cycle", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic rand_fetch(input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            int a;
            repeat ($urandom_range(0, 3)) tick();
            a = $urandom_range(0, 1023);
            bus.if_req = 1'b1; bus.if_addr = AW'(a);
            push_if(a);
            t = 0;
            do begin tick(); t++; end while (!bus.if_ack && t < 400);
            check("if_ack_timeout", {31'd0, bus.if_ack}, 32'd1);
            bus.if_req = 1'b0;
        end
    endtask

    task automatic rand_data(input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            int a;
            bit we;
            logic [DW-1:0] wd;
            repeat ($urandom_range(0, 3)) tick();
            a = $urandom_range(1024, 2047);
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = AW'(a); bus.d_wdata = wd;
            push_d(we, a, wd);
            t = 0;
            do begin tick(); t++; end while (!bus.d_ack && t < 400);
            check("d_ack_timeout", {31'd0, bus.d_ack}, 32'd1);
            bus.d_req = 1'b0;
        end
    endtask

    initial begin
        bit seq [3];
        bit exp_seq [3];
        int got;
        int t;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        d_model = 32'd0;

        // Reset state.
        rst = 1'b1;
        tick(); tick();
        check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_acks", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
        check("rst_if_rdata", bus.if_rdata, 32'd0);
        check("rst_d_rdata", bus.d_rdata, 32'd0);
        check("rst_mem_addr", {21'd0, bus.mem_addr}, 32'd0);
        rst = 1'b0;
        tick();

        // Fetch read of address 5, then data write/read of address 9.
        lat_txn(1'b0, 1'b0, 5, 32'd0);
        check("if_rdata_hold", bus.if_rdata, 32'hDEADBEEF);
        lat_txn(1'b1, 1'b1, 9, 32'h12345678);
        check("d_rdata_after_write", bus.d_rdata, 32'd0);
        lat_txn(1'b1, 1'b0, 9, 32'd0);
        check("d_rdata_readback", bus.d_rdata, 32'h12345678);

        // Reset in the second access cycle abandons the transaction.
        bus.if_req = 1'b1; bus.if_addr = AW'(20);
        tick();
        tick();
        check("rst_mid_mem_en_before", {31'd0, bus.mem_en}, 32'd1);
        rst = 1'b1; bus.if_req = 1'b0;
        tick();
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_mid_mem_en", {31'd0, bus.mem_en}, 32'd0);
        rst = 1'b0; d_model = 32'd0;
        repeat (5) begin
            tick();
            check("rst_mid_no_ack", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
        end
        lat_txn(1'b0, 1'b0, 20, 32'd0);

        // Data request dropped mid-transaction with a fetch pending.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = AW'(1100);
        push_d(1'b0, 1100, 32'd0);
        tick();
        bus.if_req = 1'b1; bus.if_addr = AW'(33);
        push_if(33);
        tick();
        bus.d_req = 1'b0;
        tick();
        check("drop_d_ack", {31'd0, bus.d_ack}, 32'd1);
        tick();
        check("drop_d_ack_once", {31'd0, bus.d_ack}, 32'd0);
        tick();
        check("drop_if_granted", {31'd0, bus.mem_en}, 32'd1);
        check("drop_if_addr", {21'd0, bus.mem_addr}, 32'd33);
        tick(); tick();
        check("drop_if_ack", {31'd0, bus.if_ack}, 32'd1);
        bus.if_req = 1'b0;
        tick();

        // Both requests held from reset: tie-break order.
        rst = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = AW'(100);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = AW'(1500);
        tick();
        check("stall_in_reset", {31'd0, bus.stall}, 32'd1);
        tick();
        d_model = 32'd0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        exp_seq = '{1'b0, 1'b1, 1'b0};
`else
        exp_seq = '{1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 3; i++) begin
            if (exp_seq[i]) push_d(1'b0, 1500, 32'd0);
            else push_if(100);
        end
        rst = 1'b0;
        got = 0; t = 0;
        while (got < 3 && t < 60) begin
            tick(); t++;
            if (bus.if_ack || bus.d_ack) begin
                seq[got] = bus.d_ack;
                got++;
            end
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        check("tie_ack_count", got, 32'd3);
        for (int i = 0; i < 3; i++) check("tie_grant_order", {31'd0, seq[i]}, {31'd0, exp_seq[i]});
        tick();

        // Randomized traffic on both ports.
        fork
            rand_fetch(30);
            rand_data(30);
        join
        repeat (5) tick();
        check("if_queue_drained", exp_if_q.size(), 32'd0);
        check("d_queue_drained", exp_d_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters SHALL be ADDR_W, default 11, word address width; DATA_W, default 32, data width; WAIT_CYCLES, default 2, SRAM access cycles per transaction (a value of 0 is treated as 1).
REQ-002 The clocking SHALL be one clock; reset is synchronous and active-high; the ports are named clk and rst.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 if_req  input  1  fetch request; held high until if_ack.
REQ-006 if_addr  input  ADDR_W  fetch address.
REQ-007 if_rdata  output  DATA_W  registered fetch read data.
REQ-008 if_ack  output  1  one-cycle fetch completion pulse.
REQ-009 d_req  input  1  data request; held high until d_ack.
REQ-010 d_we  input  1  data write (1) or read (0).
REQ-011 d_addr  input  ADDR_W  data address.
REQ-012 d_wdata  input  DATA_W  data write value.
REQ-013 d_rdata  output  DATA_W  registered data read value.
REQ-014 d_ack  output  1  one-cycle data completion pulse.
REQ-015 mem_en  output  1  SRAM chip enable.
REQ-016 mem_we  output  1  SRAM write enable.
REQ-017 mem_addr  output  ADDR_W  SRAM address.
REQ-018 mem_wdata  output  DATA_W  SRAM write data.
REQ-019 mem_rdata  input  DATA_W  SRAM read data, valid in the last access cycle.
REQ-020 stall  output  1  high while any request is pending and its ack is not asserted in that cycle.
REQ-021 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-022 The FSM SHALL have the states IDLE, ACCESS and DONE.
REQ-023 IDLE with no request SHALL remain IDLE, with mem_en=0 and mem_we=0.
REQ-024 IDLE with at least one request SHALL select an owner, latch the owner's address, write data and write enable into internal registers, load the wait counter with WAIT_CYCLES-1, and go to ACCESS.
REQ-025 ACCESS SHALL drive mem_en=1, mem_addr and mem_wdata from the latched registers, and mem_we=1 only for a data-port write.
REQ-026 ACCESS SHALL decrement the counter each cycle.
REQ-027 On the ACCESS cycle with counter=0, the block SHALL capture mem_rdata into the owner's rdata register on reads (a write leaves rdata unchanged) and go to DONE.
REQ-028 DONE SHALL pulse the owner's ack for exactly one cycle with mem_en=0, then go to IDLE.
REQ-029 Latency: a request first seen in IDLE at cycle T SHALL give ACCESS cycles T+1..T+WAIT_CYCLES and the ack at T+WAIT_CYCLES+1.
REQ-030 There SHALL be at most one transaction in flight, and the non-owner request SHALL wait without being acked.
REQ-031 A request deasserted mid-transaction SHALL not abort it; the transaction completes and the ack still pulses.
REQ-032 An ack SHALL never coincide with mem_en=1.
REQ-033 A request held high through DONE SHALL be re-arbitrated in the following IDLE cycle as a new transaction.
REQ-034 if_rdata and d_rdata SHALL hold their values between transactions.

Reset
REQ-035 rst=1 at a clock edge SHALL force IDLE and clear the counter, latched registers, if_rdata, d_rdata, if_ack, d_ack, mem_en, mem_we, mem_addr, mem_wdata, busy and the last-grant register; last-grant resets to "data".
REQ-036 rst asserted mid-ACCESS SHALL abandon the transaction with no ack, and any write is cut off after that edge.
REQ-037 stall SHALL be combinational from the request inputs, so it is high after reset if any request is present.

Configuration
REQ-038 When macro SRAM_ARB_ROUND_ROBIN_EN is defined, a tie (both requests high in IDLE) SHALL be granted to the port not granted last, so the first tie after reset goes to fetch; the last-grant register updates on every grant.
REQ-039 When SRAM_ARB_ROUND_ROBIN_EN is undefined, ties SHALL always be granted to the data port, and the last-grant register is not implemented.

Verification
REQ-040 Reset, then if_req=1, if_addr=5, mem_rdata=0xDEADBEEF, WAIT_CYCLES=2 -> mem_en high 2 cycles at addr 5, if_ack at T+3, if_rdata=0xDEADBEEF.
REQ-041 d_req=1, d_we=1, d_addr=9, d_wdata=0x12345678 -> mem_we=1 for 2 cycles at addr 9, d_ack at T+3, d_rdata unchanged.
REQ-042 if_req and d_req both high from reset, both held -> with the macro, grant order fetch, data, fetch; without it, data wins every tie.
REQ-043 rst pulsed in the second ACCESS cycle -> no ack, busy=0 and mem_en=0 next cycle, and a fresh request completes normally.
REQ-044 d_req dropped after the first ACCESS cycle -> d_ack still pulses once at T+3, and a pending if_req is granted in the following IDLE.
REQ-045 Any run -> stall equals (if_req&~if_ack)|(d_req&~d_ack) every cycle, and an ack is never high together with mem_en.
